comb_delay_scheduler: RTL and testbench

COMB_DELAY_SCHEDULER -- requirements
Module: comb_delay_scheduler

---
 rtl/comb_delay_scheduler.sv | 166 ++++++++++++++++
 tb/tb_comb_delay_scheduler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comb_delay_scheduler.sv
// comb_delay_scheduler
//   Time-multiplexes NUM_CH circular delay lines over one single-port RAM.
//   After reset the whole RAM is zeroed (CLEAR). Each accepted sample_tick
//   then runs one service round of RD/WR pairs, one pair per channel.
//   The RD cycle fetches the delayed sample. The WR cycle stores the new
//   sample and captures the fetched one.
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   enable, sample_tick : a tick starts a round only when enable is high
//   in_bus, len_bus     : per-channel samples / delay lengths, channel c at
//                         [c*WIDTH +: WIDTH] / [c*LW +: LW]
//   mem_addr/we/wdata   : RAM request; mem_rdata is valid one cycle later
//   out_data/out_ch     : delayed sample and its channel, qualified by out_valid
//   done                : one-cycle pulse after the last channel is serviced
//   busy                : high in CLEAR, RD and WR
//   overrun             : sticky; set when a tick arrives while busy
module comb_delay_scheduler #(
  parameter  int WIDTH  = 12,
  parameter  int MAXLEN = 2048,
  parameter  int NUM_CH = 4,
  localparam int AW     = $clog2(NUM_CH * MAXLEN),
  localparam int LW     = $clog2(MAXLEN) + 1,
  localparam int CW     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic                    sample_tick,
  input  logic [NUM_CH*WIDTH-1:0] in_bus,
  input  logic [NUM_CH*LW-1:0]    len_bus,
  output logic [AW-1:0]           mem_addr,
  output logic                    mem_we,
  output logic [WIDTH-1:0]        mem_wdata,
  input  logic [WIDTH-1:0]        mem_rdata,
  output logic [WIDTH-1:0]        out_data,
  output logic [CW-1:0]           out_ch,
  output logic                    out_valid,
  output logic                    done,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PW    = LW - 1;
  localparam int TOTAL = NUM_CH * MAXLEN;

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_RD, S_WR} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_clr_addr;
  logic [CW-1:0]    r_ch;
  logic [PW-1:0]    r_wptr [NUM_CH];
  logic [WIDTH-1:0] r_in   [NUM_CH];
  logic [PW-1:0]    r_len  [NUM_CH];
  logic [WIDTH-1:0] r_out_data;
  logic [CW-1:0]    r_out_ch;
  logic             r_out_valid;
  logic             r_done;
  logic             r_overrun;

  logic             w_tick;
  logic             w_last;
  logic [AW-1:0]    w_base;
  logic [PW-1:0]    w_rd_off;
  logic [AW-1:0]    w_addr;
  logic             w_we;
  logic [WIDTH-1:0] w_wdata;

  // Lengths are stored modulo MAXLEN: a length of MAXLEN becomes 0, which
  // gives the same read offset as the write pointer (read-before-write
  // returns the oldest sample).
  function automatic logic [PW-1:0] f_len(input logic [LW-1:0] l);
    if (l == '0)                 return PW'(1);
    else if (l >= LW'(MAXLEN))   return '0;
    else                         return l[PW-1:0];
  endfunction

  assign w_tick = sample_tick && enable;
  assign w_last = (r_ch == CW'(NUM_CH - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_addr      = '0;
    w_we        = 1'b0;
    w_wdata     = '0;
    w_base      = AW'(r_ch) << PW;
    w_rd_off    = r_wptr[r_ch] - r_len[r_ch];
    unique case (r_state)
      S_CLEAR: begin
        w_addr = r_clr_addr;
        w_we   = 1'b1;
        if (r_clr_addr == AW'(TOTAL - 1)) w_state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (w_tick) w_state_nxt = S_RD;
      end
      S_RD: begin
        w_addr      = w_base + AW'(w_rd_off);
        w_state_nxt = S_WR;
      end
      S_WR: begin
        w_addr      = w_base + AW'(r_wptr[r_ch]);
        w_we        = 1'b1;
        w_wdata     = r_in[r_ch];
        w_state_nxt = w_last ? S_IDLE : S_RD;
      end
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_CLEAR;
      r_clr_addr  <= '0;
      r_ch        <= '0;
      r_out_data  <= '0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        r_wptr[i] <= '0;
        r_in[i]   <= '0;
        r_len[i]  <= '0;
      end
    end else begin
      r_state     <= w_state_nxt;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      if (w_tick && (r_state != S_IDLE)) r_overrun <= 1'b1;
      unique case (r_state)
        S_CLEAR: r_clr_addr <= r_clr_addr + AW'(1);
        S_IDLE: begin
          if (w_tick) begin
            r_ch <= '0;
            for (int unsigned c = 0; c < NUM_CH; c++) begin
              r_in[c]  <= in_bus[c*WIDTH +: WIDTH];
              r_len[c] <= f_len(len_bus[c*LW +: LW]);
            end
          end
        end
        S_RD: ;
        S_WR: begin
          r_out_data   <= mem_rdata;
          r_out_ch     <= r_ch;
          r_out_valid  <= 1'b1;
          r_wptr[r_ch] <= r_wptr[r_ch] + PW'(1);
          if (w_last) r_done <= 1'b1;
          else        r_ch   <= r_ch + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_addr  = w_addr;
  assign mem_we    = w_we;
  assign mem_wdata = w_wdata;
  assign out_data  = r_out_data;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_comb_delay_scheduler.sv
module tb_comb_delay_scheduler;

  localparam int WIDTH  = 12;
  localparam int MAXLEN = 8;
  localparam int NUM_CH = 2;
  localparam int AW     = $clog2(NUM_CH * MAXLEN);
  localparam int LW     = $clog2(MAXLEN) + 1;
  localparam int CW     = 1;
  localparam int TOTAL  = NUM_CH * MAXLEN;
  localparam int IN_W   = NUM_CH * WIDTH;
  localparam int LEN_W  = NUM_CH * LW;

  logic              clk;
  logic              rst;
  logic              enable;
  logic              sample_tick;
  logic [IN_W-1:0]   in_bus;
  logic [LEN_W-1:0]  len_bus;
  logic [AW-1:0]     mem_addr;
  logic              mem_we;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic [WIDTH-1:0]  out_data;
  logic [CW-1:0]     out_ch;
  logic              out_valid;
  logic              done;
  logic              busy;
  logic              overrun;

  comb_delay_scheduler #(.WIDTH(WIDTH), .MAXLEN(MAXLEN), .NUM_CH(NUM_CH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .sample_tick(sample_tick),
    .in_bus(in_bus), .len_bus(len_bus),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
    .done(done), .busy(busy), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one cycle of read latency, read-before-write.
  logic [WIDTH-1:0] ram [TOTAL];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time base: edge_n counts rising edges; "cycle e" is the cycle after edge e.
  int  edge_n    = 0;
  bit  started   = 0;
  int  clr_start = 0;
  int  idle_from = 0;    // first cycle in which the DUT is idle again
  bit  m_ovr     = 0;
  int  rounds    = 0;    // accepted rounds since reset
  int  hist [NUM_CH][$]; // samples per channel, one per round since reset
  int  ev_vd   [int];
  int  ev_vc   [int];
  bit  ev_done [int];
  bit  ev_we   [int];
  int  ev_addr [int];
  int  ev_wd   [int];
  int  cap0 [$];
  int  cap1 [$];
  int  n_we   = 0;
  int  n_done = 0;

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > MAXLEN) return MAXLEN;
    return l;
  endfunction

  task automatic model_edge();
    edge_n++;
    if (rst) begin
      started   = 1;
      clr_start = edge_n;
      idle_from = edge_n + TOTAL;
      m_ovr     = 0;
      rounds    = 0;
      for (int c = 0; c < NUM_CH; c++) hist[c].delete();
      for (int k = edge_n; k <= edge_n + 2*NUM_CH + 2; k++) begin
        ev_vd.delete(k); ev_vc.delete(k); ev_done.delete(k);
        ev_we.delete(k); ev_addr.delete(k); ev_wd.delete(k);
      end
      cap0.delete();
      cap1.delete();
    end else if (started && sample_tick && enable) begin
      // DUT state at this edge is the one of cycle edge_n-1
      if (edge_n - 1 < idle_from) begin
        m_ovr = 1;
      end else begin
        for (int c = 0; c < NUM_CH; c++) begin
          int l, s;
          l = clamp_len(int'(len_bus[c*LW +: LW]));
          s = int'(in_bus[c*WIDTH +: WIDTH]);
          ev_we[edge_n + 2*c]       = 0;
          ev_addr[edge_n + 2*c]     = c*MAXLEN + (((rounds - l) % MAXLEN) + MAXLEN) % MAXLEN;
          ev_we[edge_n + 2*c + 1]   = 1;
          ev_addr[edge_n + 2*c + 1] = c*MAXLEN + rounds % MAXLEN;
          ev_wd[edge_n + 2*c + 1]   = s;
          ev_vd[edge_n + 2*c + 2]   = (rounds >= l) ? hist[c][rounds - l] : 0;
          ev_vc[edge_n + 2*c + 2]   = c;
          hist[c].push_back(s);
        end
        ev_done[edge_n + 2*NUM_CH] = 1;
        idle_from = edge_n + 2*NUM_CH;
        rounds++;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    int e;
    forever begin
      @(negedge clk);
      if (started) begin
        e = edge_n;
        chk("busy", busy, e < idle_from);
        chk("overrun", overrun, m_ovr);
        chk("out_valid", out_valid, ev_vd.exists(e));
        if (out_valid && ev_vd.exists(e)) begin
          chk("out_data", out_data, ev_vd[e]);
          chk("out_ch", out_ch, ev_vc[e]);
          if (out_ch == 0) cap0.push_back(int'(out_data));
          else             cap1.push_back(int'(out_data));
        end
        chk("done", done, ev_done.exists(e));
        if (done) n_done++;
        if (e >= clr_start && e < clr_start + TOTAL) begin
          chk("clr_we", mem_we, 1);
          chk("clr_addr", mem_addr, e - clr_start);
          chk("clr_wdata", mem_wdata, 0);
        end else if (ev_we.exists(e)) begin
          chk("rnd_we", mem_we, ev_we[e]);
          chk("rnd_addr", mem_addr, ev_addr[e]);
          if (ev_we[e]) chk("rnd_wdata", mem_wdata, ev_wd[e]);
        end else begin
          chk("idle_we", mem_we, 0);
        end
        if (mem_we) n_we++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wait_clear(input string name);
    int nwe0;
    nwe0 = n_we;
    for (int i = 0; i < 4*TOTAL && busy; i++) cycle();
    chk({name, "_clear_done"}, busy, 0);
    chk({name, "_clear_writes"}, n_we - nwe0, TOTAL);
  endtask

  task automatic do_round(input int in0, input int in1, input int l0, input int l1);
    in_bus      = {WIDTH'(in1), WIDTH'(in0)};
    len_bus     = {LW'(l1), LW'(l0)};
    enable      = 1'b1;
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    repeat (2*NUM_CH + 1) cycle();
  endtask

  initial begin : stim
    int nd0, nwe0;
    rst = 1'b1; enable = 1'b0; sample_tick = 1'b0; in_bus = '0; len_bus = '0;
    cycle();
    rst = 1'b0;
    chk("rst_busy", busy, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_addr", mem_addr, 0);
    wait_clear("init");

    // ch0 len 3, ch1 len MAXLEN
    for (int r = 0; r < 10; r++) do_round(r + 1, 100 + r, 3, MAXLEN);
    chk("cap0_size", cap0.size(), 10);
    chk("cap1_size", cap1.size(), 10);
    chk("len3_r0", cap0[0], 0);
    chk("len3_r2", cap0[2], 0);
    chk("len3_r3", cap0[3], 1);
    chk("len3_r4", cap0[4], 2);
    chk("lenmax_r7", cap1[7], 0);
    chk("lenmax_r8", cap1[8], 100);
    chk("lenmax_r9", cap1[9], 101);
    // len 0 acts as len 1; len above MAXLEN clamps to MAXLEN
    do_round(50, 200, 0, 15);
    chk("len0_as_1", cap0[10], 10);
    chk("len15_clamp", cap1[10], 102);

    // back-to-back tick: second one dropped, round still 4 cycles
    nd0 = n_done;
    in_bus = '0; len_bus = {LW'(1), LW'(1)}; enable = 1'b1;
    sample_tick = 1'b1;
    cycle();
    cycle();
    sample_tick = 1'b0;
    repeat (2*NUM_CH) cycle();
    chk("ovr_set", overrun, 1);
    chk("ovr_one_done", n_done - nd0, 1);

    // reset while servicing channel 1 (WR)
    in_bus = {WIDTH'(77), WIDTH'(66)};
    sample_tick = 1'b1;
    cycle();
    sample_tick = 1'b0;
    repeat (3) cycle();
    chk("wr1_we", mem_we, 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("midrst_addr", mem_addr, 0);
    chk("midrst_we", mem_we, 1);
    chk("midrst_overrun", overrun, 0);
    chk("midrst_valid", out_valid, 0);
    wait_clear("midrst");

    // enable low: ticks ignored, nothing written, no overrun
    nwe0 = n_we;
    enable = 1'b0; sample_tick = 1'b1;
    repeat (6) cycle();
    sample_tick = 1'b0;
    chk("en0_writes", n_we - nwe0, 0);
    chk("en0_overrun", overrun, 0);
    chk("en0_busy", busy, 0);

    // zeros after reset until refilled
    do_round(7, 1, 2, 1);
    do_round(8, 2, 2, 1);
    do_round(9, 3, 2, 1);
    chk("refill_size", cap0.size(), 3);
    chk("refill_r0", cap0[0], 0);
    chk("refill_r1", cap0[1], 0);
    chk("refill_r2", cap0[2], 7);
    chk("refill_ch1_r1", cap1[1], 1);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rst         = ($urandom % 250 == 0);
      sample_tick = ($urandom % 3 == 0);
      enable      = ($urandom % 6 != 0);
      in_bus      = IN_W'($urandom);
      len_bus     = LEN_W'($urandom);
      cycle();
    end
    rst = 1'b0; sample_tick = 1'b0;
    repeat (4*TOTAL) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
